mul_acc_pipe_8bit: RTL

Downstream consumer of the pipelined 8-bit multiplier. It sums fixed-size groups of consecutive products (acc_len per group) and presents each group sum to a downstream consumer over a valid/ready interface. The multiplier cannot be stalled, so completed sums are buffered in a 2-entry FIFO. A sticky flag records any sum dropped while the FIFO is full.

---
 rtl/mul_acc_pipe_8bit_if.sv | 29 ++
 rtl/mul_acc_pipe_8bit.sv | 115 +++++++++++
 2 files changed

// File: rtl/mul_acc_pipe_8bit_if.sv
// Product input, group-sum output and status bundle for mul_acc_pipe_8bit.
interface mul_acc_pipe_8bit_if #(
  parameter int size    = 8,
  parameter int acc_len = 4,
  parameter int acc_w   = 18
);
  localparam int cw = $clog2(acc_len);

  logic                mul_en_in;
  logic [2*size-1:0]   mul_in;
  logic                acc_clr;
  logic                acc_ready;
  logic                acc_valid;
  logic [acc_w-1:0]    acc_out;
  logic                acc_overflow;
  logic [cw-1:0]       grp_cnt;

  // Producer / consumer side (multiplier plus downstream sink)
  modport master (
    output mul_en_in, mul_in, acc_clr, acc_ready,
    input  acc_valid, acc_out, acc_overflow, grp_cnt
  );

  // Accumulator side
  modport slave (
    input  mul_en_in, mul_in, acc_clr, acc_ready,
    output acc_valid, acc_out, acc_overflow, grp_cnt
  );
endinterface

// File: rtl/mul_acc_pipe_8bit.sv
// Group accumulator behind the pipelined 8-bit multiplier.
// Sums acc_len consecutive products and hands each sum to a downstream
// consumer through a 2-entry FIFO. The multiplier cannot be stalled, so a
// sum arriving while the FIFO is full (and not popping) is dropped and
// recorded in a sticky overflow flag.
module mul_acc_pipe_8bit #(
  parameter int size    = 8,
  parameter int acc_len = 4,
  parameter int acc_w   = 18
) (
  input  logic               clk,
  input  logic               rst,
  mul_acc_pipe_8bit_if.slave bus
);
  localparam int cw = $clog2(acc_len);

  logic [acc_w-1:0] acc_reg;
  logic [cw-1:0]    grp_cnt_reg;
  logic [acc_w-1:0] head_reg;
  logic [acc_w-1:0] tail_reg;
  logic [1:0]       count_reg;
  logic             ovf_reg;

  logic [acc_w-1:0] prod_ext;
  logic [acc_w-1:0] sum;
  logic             last_prod;
  logic             push;
  logic             pop;

  // Product is zero-extended; the group sum wraps modulo 2^acc_w.
  assign prod_ext  = acc_w'(bus.mul_in);
  assign sum       = acc_reg + prod_ext;
  assign last_prod = (grp_cnt_reg == cw'(acc_len - 1));
  // A product arriving with acc_clr opens a new group, so it never completes one.
  assign push      = bus.mul_en_in & ~bus.acc_clr & last_prod;
  assign pop       = (count_reg != 2'd0) & bus.acc_ready;

  // Partial-group accumulator and product counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      grp_cnt_reg <= '0;
    end else if (bus.acc_clr) begin
      if (bus.mul_en_in) begin
        acc_reg     <= prod_ext;
        grp_cnt_reg <= cw'(1);
      end else begin
        acc_reg     <= '0;
        grp_cnt_reg <= '0;
      end
    end else if (bus.mul_en_in) begin
      if (push) begin
        acc_reg     <= '0;
        grp_cnt_reg <= '0;
      end else if (grp_cnt_reg == '0) begin
        acc_reg     <= prod_ext;
        grp_cnt_reg <= grp_cnt_reg + cw'(1);
      end else begin
        acc_reg     <= sum;
        grp_cnt_reg <= grp_cnt_reg + cw'(1);
      end
    end
  end

  // Two-register FIFO: head drives acc_out directly and keeps its value
  // when the FIFO drains, tail holds the second entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
      ovf_reg   <= 1'b0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (push) begin
            head_reg  <= sum;
            count_reg <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head_reg <= sum;
            2'b10: begin
              tail_reg  <= sum;
              count_reg <= 2'd2;
            end
            2'b01: count_reg <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          case ({push, pop})
            2'b11: begin
              head_reg <= tail_reg;
              tail_reg <= sum;
            end
            2'b01: begin
              head_reg  <= tail_reg;
              count_reg <= 2'd1;
            end
            2'b10: ovf_reg <= 1'b1;
            default: ;
          endcase
        end
        default: count_reg <= 2'd0;
      endcase
    end
  end

  assign bus.acc_valid    = (count_reg != 2'd0);
  assign bus.acc_out      = head_reg;
  assign bus.acc_overflow = ovf_reg;
  assign bus.grp_cnt      = grp_cnt_reg;
endmodule
